breakout_game_ctrl: RTL and testbench

BREAKOUT_GAME_CTRL -- requirements
Module: breakout_game_ctrl

---
 rtl/breakout_pkg.sv | 31 +++
 rtl/bcd_counter4.sv | 40 ++++
 rtl/breakout_game_ctrl.sv | 145 ++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout game controller.
// Holds the state encoding, the USB keycodes it reacts to, and the playfield limits.
package breakout_pkg;

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_LOST  = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } game_state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;

  localparam int NUM_BLOCKS  = 32;
  localparam int MAX_LIVES   = 3;
  localparam int LOST_FRAMES = 60;

  localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [5:0] LOST_LAST  = 6'(LOST_FRAMES - 1);

  // Paddle keys and space must not start a game from the menu.
  function automatic logic is_start_key(input logic [7:0] kc);
    return !(kc == KEY_NONE || kc == KEY_A || kc == KEY_D || kc == KEY_SPACE);
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit packed BCD up-counter with synchronous clear, saturating at 9999.
// Count updates on the edge after i_inc; clear wins over increment; no backpressure.
module bcd_counter4 (
  input  logic        clk,
  input  logic        Reset,
  input  logic        i_clear,
  input  logic        i_inc,
  output logic [15:0] o_bcd
);

  logic [15:0] r_count;
  logic [15:0] w_next;
  logic        w_carry;

  always_comb begin
    w_next  = r_count;
    w_carry = i_inc && (r_count != 16'h9999);
    for (int d = 0; d < 4; d++) begin
      if (w_carry) begin
        if (r_count[d*4 +: 4] == 4'd9) begin
          w_next[d*4 +: 4] = 4'd0;
        end else begin
          w_next[d*4 +: 4] = r_count[d*4 +: 4] + 4'd1;
          w_carry          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset || i_clear) begin
      r_count <= 16'h0000;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_bcd = r_count;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: menu, serve, play, life loss, game over and win handling.
// All outputs are registered (one-edge latency from inputs); event pulses are never stalled.
module breakout_game_ctrl
  import breakout_pkg::*;
(
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic [7:0]            keycode,
  input  logic                  block_hit,
  input  logic [4:0]            block_idx,
  input  logic                  ball_lost,
  output logic [NUM_BLOCKS-1:0] block_array,
  output logic [1:0]            lives,
  output logic [15:0]           score_bcd,
  output logic                  start_menu,
  output logic                  ball_en,
  output logic                  ball_reset,
  output logic [2:0]            game_state
);

  game_state_t           r_state;
  logic [NUM_BLOCKS-1:0] r_blocks;
  logic [1:0]            r_lives;
  logic [5:0]            r_frame_cnt;
  logic                  r_key_armed;

  game_state_t           w_state_nxt;
  logic [NUM_BLOCKS-1:0] w_blocks_nxt;
  logic [NUM_BLOCKS-1:0] w_blocks_hit;
  logic [1:0]            w_lives_nxt;
  logic [5:0]            w_cnt_nxt;
  logic                  w_armed_nxt;
  logic                  w_hit_ok;
  logic                  w_score_inc;
  logic                  w_score_clr;

  assign w_hit_ok     = block_hit && r_blocks[block_idx];
  assign w_blocks_hit = r_blocks & ~(32'd1 << block_idx);

  always_comb begin
    w_state_nxt  = r_state;
    w_blocks_nxt = r_blocks;
    w_lives_nxt  = r_lives;
    w_cnt_nxt    = r_frame_cnt;
    w_armed_nxt  = r_key_armed;
    w_score_inc  = 1'b0;
    w_score_clr  = 1'b0;

    case (r_state)
      ST_MENU: begin
        if (is_start_key(keycode)) begin
          w_state_nxt  = ST_SERVE;
          w_blocks_nxt = '1;
          w_lives_nxt  = LIVES_INIT;
          w_score_clr  = 1'b1;
        end
      end

      ST_SERVE: begin
        if (keycode == KEY_SPACE) begin
          w_state_nxt = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (w_hit_ok) begin
          w_blocks_nxt = w_blocks_hit;
          w_score_inc  = 1'b1;
        end
        // Clearing the last block beats a simultaneous ball loss.
        if (w_hit_ok && (w_blocks_hit == '0)) begin
          w_state_nxt = ST_WIN;
          w_armed_nxt = 1'b0;
        end else if (ball_lost) begin
          if (r_lives <= 2'd1) begin
            w_lives_nxt = 2'd0;
            w_state_nxt = ST_OVER;
            w_armed_nxt = 1'b0;
          end else begin
            w_lives_nxt = r_lives - 2'd1;
            w_state_nxt = ST_LOST;
            w_cnt_nxt   = 6'd0;
          end
        end
      end

      ST_LOST: begin
        if (frame_tick) begin
          if (r_frame_cnt == LOST_LAST) begin
            w_state_nxt = ST_SERVE;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_cnt_nxt = r_frame_cnt + 6'd1;
          end
        end
      end

      ST_OVER, ST_WIN: begin
        // Space only returns to the menu after a key release seen inside this state.
        if (keycode == KEY_SPACE && r_key_armed) begin
          w_state_nxt = ST_MENU;
        end else if (keycode == KEY_NONE) begin
          w_armed_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_MENU;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state     <= ST_MENU;
      r_blocks    <= '1;
      r_lives     <= LIVES_INIT;
      r_frame_cnt <= 6'd0;
      r_key_armed <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_blocks    <= w_blocks_nxt;
      r_lives     <= w_lives_nxt;
      r_frame_cnt <= w_cnt_nxt;
      r_key_armed <= w_armed_nxt;
    end
  end

  bcd_counter4 u_score (
    .clk     (clk),
    .Reset   (Reset),
    .i_clear (w_score_clr),
    .i_inc   (w_score_inc),
    .o_bcd   (score_bcd)
  );

  assign block_array = r_blocks;
  assign lives       = r_lives;
  assign start_menu  = (r_state == ST_MENU);
  assign ball_en     = (r_state == ST_PLAY);
  assign ball_reset  = (r_state == ST_SERVE);
  assign game_state  = r_state;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Scoreboard bench for breakout_game_ctrl: directed game scenarios then randomized play.
module tb_breakout_game_ctrl;
  import breakout_pkg::*;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic        block_hit = 1'b0;
  logic [4:0]  block_idx = 5'd0;
  logic        ball_lost = 1'b0;
  logic [31:0] block_array;
  logic [1:0]  lives;
  logic [15:0] score_bcd;
  logic        start_menu;
  logic        ball_en;
  logic        ball_reset;
  logic [2:0]  game_state;

  breakout_game_ctrl dut (
    .clk         (clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .keycode     (keycode),
    .block_hit   (block_hit),
    .block_idx   (block_idx),
    .ball_lost   (ball_lost),
    .block_array (block_array),
    .lives       (lives),
    .score_bcd   (score_bcd),
    .start_menu  (start_menu),
    .ball_en     (ball_en),
    .ball_reset  (ball_reset),
    .game_state  (game_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic        sm;
    logic        be;
    logic        br;
    logic [1:0]  lv;
    logic [15:0] sc;
    logic [31:0] ba;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: game rules on plain integers and a block bitmap.
  int        m_state = ST_MENU;
  bit [31:0] m_blocks = '1;
  int        m_lives = 3;
  int        m_score = 0;
  int        m_frames = 0;
  bit        m_armed = 0;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [7:0] rand_key();
    logic [7:0] ktab [8];
    ktab = '{8'h00, 8'h00, 8'h2C, 8'h2C, 8'h04, 8'h07, 8'h15, 8'h00};
    ktab[7] = 8'($urandom_range(0, 255));
    return ktab[$urandom_range(0, 7)];
  endfunction

  task automatic step(input bit rst, input bit ft, input logic [7:0] kc,
                      input bit bh, input logic [4:0] bi, input bit bl);
    exp_t e;
    bit   scored;
    @(negedge clk);
    Reset = rst; frame_tick = ft; keycode = kc;
    block_hit = bh; block_idx = bi; ball_lost = bl;
    scored = 0;
    if (rst) begin
      m_state = ST_MENU; m_blocks = '1; m_lives = 3; m_score = 0; m_frames = 0; m_armed = 0;
    end else if (m_state == ST_MENU) begin
      if (!(kc == 8'h00 || kc == 8'h04 || kc == 8'h07 || kc == 8'h2C)) begin
        m_state = ST_SERVE; m_blocks = '1; m_lives = 3; m_score = 0;
      end
    end else if (m_state == ST_SERVE) begin
      if (kc == 8'h2C) m_state = ST_PLAY;
    end else if (m_state == ST_PLAY) begin
      if (bh && m_blocks[bi]) begin
        m_blocks[bi] = 1'b0;
        m_score = (m_score < 9999) ? m_score + 1 : 9999;
        scored = 1;
      end
      if (scored && m_blocks == 0) begin
        m_state = ST_WIN; m_armed = 0;
      end else if (bl) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        if (m_lives == 0) begin
          m_state = ST_OVER; m_armed = 0;
        end else begin
          m_state = ST_LOST; m_frames = 0;
        end
      end
    end else if (m_state == ST_LOST) begin
      if (ft) begin
        m_frames++;
        if (m_frames == 60) begin
          m_state = ST_SERVE; m_frames = 0;
        end
      end
    end else begin
      if (kc == 8'h2C && m_armed) m_state = ST_MENU;
      else if (kc == 8'h00) m_armed = 1;
    end
    @(posedge clk);
    #1;
    e.st = 3'(m_state);
    e.sm = (m_state == ST_MENU);
    e.be = (m_state == ST_PLAY);
    e.br = (m_state == ST_SERVE);
    e.lv = 2'(m_lives);
    e.sc = to_bcd(m_score);
    e.ba = m_blocks;
    exp_q.push_back(e);
  endtask

  task automatic rand_step(input bit ft);
    step(0, ft, rand_key(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
         1'($urandom_range(0, 1)));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) rand_step(0);
      rand_step(1);
    end
  endtask

  task automatic hit(input int idx, input bit bl);
    step(0, 1'($urandom_range(0, 1)), 8'h00, 1, 5'(idx), bl);
  endtask

  initial begin : monitor
    exp_t e;
    bit   bad;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        bad = 0;
        if (game_state !== e.st) begin
          $display("FAIL game_state vec %0d: got %0d want %0d", vectors, game_state, e.st); bad = 1;
        end
        if (start_menu !== e.sm || ball_en !== e.be || ball_reset !== e.br) begin
          $display("FAIL decode vec %0d: got menu/en/rst %b%b%b want %b%b%b", vectors,
                   start_menu, ball_en, ball_reset, e.sm, e.be, e.br); bad = 1;
        end
        if (lives !== e.lv) begin
          $display("FAIL lives vec %0d: got %0d want %0d", vectors, lives, e.lv); bad = 1;
        end
        if (score_bcd !== e.sc) begin
          $display("FAIL score vec %0d: got %h want %h", vectors, score_bcd, e.sc); bad = 1;
        end
        if (block_array !== e.ba) begin
          $display("FAIL blocks vec %0d: got %h want %h", vectors, block_array, e.ba); bad = 1;
        end
        if (bad) miscompares++;
      end
    end
  end

  initial begin : stimulus
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 1, 8'h15, 1, 3, 1);
    // Menu ignores no-key, paddle keys and space; any other key starts.
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h04, 0, 0, 0);
    step(0, 0, 8'h07, 1, 2, 1);
    step(0, 0, 8'h2C, 0, 0, 0);
    step(0, 0, 8'h15, 0, 0, 0);
    step(0, 1, 8'h15, 1, 3, 1);
    step(0, 0, 8'h2C, 0, 0, 0);
    hit(5, 0);
    hit(5, 0);
    for (int i = 20; i < 29; i++) hit(i, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    ticks(60);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h2C, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    ticks(30);
    step(1, 1, 8'h15, 1, 7, 1);
    step(0, 0, 8'h15, 0, 0, 0);
    step(0, 0, 8'h2C, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 8'h00, 0, 0, 1);
      ticks(59);
      step(0, 0, 8'h00, 0, 0, 0);
      step(0, 1, 8'h00, 0, 0, 0);
      step(0, 0, 8'h2C, 0, 0, 0);
    end
    step(0, 0, 8'h2C, 0, 0, 1);
    repeat (5) step(0, 1, 8'h2C, 1, 1, 1);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h2C, 0, 0, 0);
    step(0, 0, 8'h15, 0, 0, 0);
    step(0, 0, 8'h2C, 0, 0, 0);
    for (int i = 0; i < 31; i++) hit(i, 0);
    hit(31, 1);
    step(0, 0, 8'h2C, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h2C, 0, 0, 0);
    for (int n = 0; n < 12000; n++) begin
      if ($urandom_range(0, 1999) == 0) begin
        step(1, 1'($urandom_range(0, 1)), rand_key(), 1, 5'($urandom_range(0, 31)), 1);
      end else begin
        step(0, 1'($urandom_range(0, 1)), rand_key(), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), ($urandom_range(0, 59) == 0));
      end
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
      miscompares++;
    end
    if (vectors < 12) begin
      $display("FAIL coverage: %0d vectors checked, required at least 12", vectors);
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
